// File: rtl/ysyx_22040237_wb_unit.sv
// Write-back unit: merges LSU loads and FIFO-buffered ALU results
// into the register-file write port, with a pending-write scoreboard.
module ysyx_22040237_wb_unit #(
  parameter int XLEN           = 64,
  parameter int ALU_FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            alu_valid,
  output logic            alu_ready,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_data,
  input  logic            lsu_valid,
  output logic            lsu_ready,
  input  logic [4:0]      lsu_rd,
  input  logic [XLEN-1:0] lsu_data,
  input  logic            iss_valid,
  input  logic [4:0]      iss_rd,
  input  logic [4:0]      rs1_addr,
  input  logic [4:0]      rs2_addr,
  output logic            rs1_busy,
  output logic            rs2_busy,
  output logic [31:0]     busy_vec,
  output logic            reg_wr_en,
  output logic [4:0]      wr_addr,
  output logic [XLEN-1:0] wr_data
);

  localparam int AW = $clog2(ALU_FIFO_DEPTH);

  logic [4:0]      r_q_rd   [ALU_FIFO_DEPTH];
  logic [XLEN-1:0] r_q_data [ALU_FIFO_DEPTH];
  logic [AW:0]     r_wptr;
  logic [AW:0]     r_rptr;
  logic            r_wen;
  logic [4:0]      r_waddr;
  logic [XLEN-1:0] r_wdata;
  logic [31:0]     r_busy;

  logic            w_full;
  logic            w_empty;
  logic            w_push;
  logic            w_lsu_sel;
  logic            w_pop;
  logic [31:0]     w_clr;
  logic [31:0]     w_set;
  logic [AW-1:0]   w_widx;
  logic [AW-1:0]   w_ridx;

  assign w_widx  = r_wptr[AW-1:0];
  assign w_ridx  = r_rptr[AW-1:0];
  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[AW] != r_rptr[AW]) &&
                   (w_widx == w_ridx);

  assign alu_ready = !w_full && !rst;
  assign lsu_ready = !rst;

  // rd==0 results complete the handshake but never occupy a slot
  assign w_push    = alu_valid && alu_ready &&
                     (alu_rd != 5'd0);
  assign w_lsu_sel = lsu_valid && (lsu_rd != 5'd0);
  assign w_pop     = !w_lsu_sel && !w_empty;

  assign w_clr = r_wen ? (32'd1 << r_waddr) : 32'd0;
  assign w_set = (iss_valid && iss_rd != 5'd0) ?
                 (32'd1 << iss_rd) : 32'd0;

  assign busy_vec  = r_busy;
  assign rs1_busy  = r_busy[rs1_addr];
  assign rs2_busy  = r_busy[rs2_addr];
  assign reg_wr_en = r_wen;
  assign wr_addr   = r_waddr;
  assign wr_data   = r_wdata;

  // FIFO storage, written at the tail on push
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_rd[w_widx]   <= alu_rd;
      r_q_data[w_widx] <= alu_data;
    end
  end

  // FIFO pointers; the extra top bit separates full from empty
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  // Output register: LSU first, then FIFO head, else idle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wen   <= 1'b0;
      r_waddr <= 5'd0;
      r_wdata <= '0;
    end else if (w_lsu_sel) begin
      r_wen   <= 1'b1;
      r_waddr <= lsu_rd;
      r_wdata <= lsu_data;
    end else if (w_pop) begin
      r_wen   <= 1'b1;
      r_waddr <= r_q_rd[w_ridx];
      r_wdata <= r_q_data[w_ridx];
    end else begin
      r_wen   <= 1'b0;
    end
  end

  // Scoreboard: clear on commit, set on issue, set wins
  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy <= 32'd0;
    end else begin
      r_busy <= ((r_busy & ~w_clr) | w_set) & ~32'd1;
    end
  end

endmodule

// File: tb/tb_ysyx_22040237_wb_unit.sv
// Bench for ysyx_22040237_wb_unit: directed vectors,
// corner sequences and a randomized queue-based model.
module tb_ysyx_22040237_wb_unit;

  localparam int XLEN  = 64;
  localparam int DEPTH = 2;

  logic            clk;
  logic            rst;
  logic            alu_valid;
  logic            alu_ready;
  logic [4:0]      alu_rd;
  logic [XLEN-1:0] alu_data;
  logic            lsu_valid;
  logic            lsu_ready;
  logic [4:0]      lsu_rd;
  logic [XLEN-1:0] lsu_data;
  logic            iss_valid;
  logic [4:0]      iss_rd;
  logic [4:0]      rs1_addr;
  logic [4:0]      rs2_addr;
  logic            rs1_busy;
  logic            rs2_busy;
  logic [31:0]     busy_vec;
  logic            reg_wr_en;
  logic [4:0]      wr_addr;
  logic [XLEN-1:0] wr_data;

  int n_chk;
  int n_fail;

  ysyx_22040237_wb_unit #(
    .XLEN(XLEN),
    .ALU_FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready),
    .alu_rd(alu_rd), .alu_data(alu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready),
    .lsu_rd(lsu_rd), .lsu_data(lsu_data),
    .iss_valid(iss_valid), .iss_rd(iss_rd),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .busy_vec(busy_vec), .reg_wr_en(reg_wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        av;
    logic [4:0]  ard;
    logic [63:0] ad;
    logic        lv;
    logic [4:0]  lrd;
    logic [63:0] ld;
    logic        iv;
    logic [4:0]  ird;
    logic        e_rdy;
    logic        e_wen;
    logic [4:0]  e_wa;
    logic [63:0] e_wd;
    logic [31:0] e_busy;
    logic        e_rs1;
  } vec_t;

  vec_t tbl [14];

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    alu_valid = v.av;
    alu_rd    = v.ard;
    alu_data  = v.ad;
    lsu_valid = v.lv;
    lsu_rd    = v.lrd;
    lsu_data  = v.ld;
    iss_valid = v.iv;
    iss_rd    = v.ird;
  endtask

  task automatic apply(input vec_t v, input string tag);
    drive(v);
    @(negedge clk);
    chk({tag, ".alu_ready"}, 64'(alu_ready), 64'(v.e_rdy));
    @(posedge clk);
    #1;
    chk({tag, ".wen"}, 64'(reg_wr_en), 64'(v.e_wen));
    chk({tag, ".waddr"}, 64'(wr_addr), 64'(v.e_wa));
    chk({tag, ".wdata"}, wr_data, v.e_wd);
    chk({tag, ".busy"}, 64'(busy_vec), 64'(v.e_busy));
    chk({tag, ".rs1_busy"}, 64'(rs1_busy), 64'(v.e_rs1));
  endtask

  function automatic vec_t mk(input logic av,
                              input logic [4:0] ard,
                              input logic [63:0] ad,
                              input logic lv,
                              input logic [4:0] lrd,
                              input logic [63:0] ld,
                              input logic iv,
                              input logic [4:0] ird,
                              input logic rdy,
                              input logic wen,
                              input logic [4:0] wa,
                              input logic [63:0] wd,
                              input logic [31:0] bz,
                              input logic r1);
    vec_t v;
    v.av = av; v.ard = ard; v.ad = ad;
    v.lv = lv; v.lrd = lrd; v.ld = ld;
    v.iv = iv; v.ird = ird;
    v.e_rdy = rdy; v.e_wen = wen;
    v.e_wa = wa; v.e_wd = wd;
    v.e_busy = bz; v.e_rs1 = r1;
    return v;
  endfunction

  // reference model state
  logic [4:0]  mq_rd [$];
  logic [63:0] mq_d  [$];
  logic [31:0] m_busy;
  logic        m_wen;
  logic [4:0]  m_waddr;
  logic [63:0] m_wdata;

  localparam logic Z  = 1'b0;
  localparam logic O  = 1'b1;
  localparam logic [4:0]  R0 = 5'd0;
  localparam logic [63:0] D0 = 64'h0;

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst = 1'b1;
    rs1_addr = 5'd9;
    rs2_addr = 5'd5;
    drive(mk(Z,R0,D0,Z,R0,D0,Z,R0,Z,Z,R0,D0,32'd0,Z));

    tbl[0]  = mk(Z,R0,D0, Z,R0,D0, O,5'd5,
                 O, Z,R0,D0, 32'h20, Z);
    tbl[1]  = mk(O,5'd5,64'h1234, Z,R0,D0, Z,R0,
                 O, Z,R0,D0, 32'h20, Z);
    tbl[2]  = mk(Z,R0,D0, Z,R0,D0, Z,R0,
                 O, O,5'd5,64'h1234, 32'h20, Z);
    tbl[3]  = mk(Z,R0,D0, Z,R0,D0, Z,R0,
                 O, Z,5'd5,64'h1234, 32'h0, Z);
    tbl[4]  = mk(O,5'd3,64'hAA, Z,R0,D0, Z,R0,
                 O, Z,5'd5,64'h1234, 32'h0, Z);
    tbl[5]  = mk(Z,R0,D0, O,5'd7,64'hBB, Z,R0,
                 O, O,5'd7,64'hBB, 32'h0, Z);
    tbl[6]  = mk(Z,R0,D0, O,5'd7,64'hBB, Z,R0,
                 O, O,5'd7,64'hBB, 32'h0, Z);
    tbl[7]  = mk(Z,R0,D0, Z,R0,D0, Z,R0,
                 O, O,5'd3,64'hAA, 32'h0, Z);
    tbl[8]  = mk(Z,R0,D0, Z,R0,D0, Z,R0,
                 O, Z,5'd3,64'hAA, 32'h0, Z);
    tbl[9]  = mk(O,R0,64'h55, O,R0,64'h66, O,R0,
                 O, Z,5'd3,64'hAA, 32'h0, Z);
    tbl[10] = mk(Z,R0,D0, Z,R0,D0, Z,R0,
                 O, Z,5'd3,64'hAA, 32'h0, Z);
    tbl[11] = mk(Z,R0,D0, O,5'd9,64'h99, O,5'd9,
                 O, O,5'd9,64'h99, 32'h200, O);
    tbl[12] = mk(Z,R0,D0, Z,R0,D0, O,5'd9,
                 O, Z,5'd9,64'h99, 32'h200, O);
    tbl[13] = mk(Z,R0,D0, Z,R0,D0, Z,R0,
                 O, Z,5'd9,64'h99, 32'h200, O);

    // reset state
    repeat (2) begin
      @(negedge clk);
      chk("rst.alu_ready", 64'(alu_ready), 64'd0);
      chk("rst.lsu_ready", 64'(lsu_ready), 64'd0);
      @(posedge clk);
      #1;
      chk("rst.wen", 64'(reg_wr_en), 64'd0);
      chk("rst.waddr", 64'(wr_addr), 64'd0);
      chk("rst.wdata", wr_data, 64'd0);
      chk("rst.busy", 64'(busy_vec), 64'd0);
    end
    rst = 1'b0;

    for (int i = 0; i < 14; i++)
      apply(tbl[i], $sformatf("vec%0d", i));

    // FIFO full under LSU pressure, wrap-around ordering
    apply(mk(O,5'd10,64'h101, O,5'd20,64'h200, Z,R0,
             O, O,5'd20,64'h200, 32'h200, O), "full0");
    apply(mk(O,5'd11,64'h102, O,5'd20,64'h201, Z,R0,
             O, O,5'd20,64'h201, 32'h200, O), "full1");
    apply(mk(O,5'd12,64'h103, O,5'd20,64'h202, Z,R0,
             Z, O,5'd20,64'h202, 32'h200, O), "full2");
    apply(mk(O,5'd12,64'h103, Z,R0,D0, Z,R0,
             Z, O,5'd10,64'h101, 32'h200, O), "full3");
    apply(mk(O,5'd12,64'h103, Z,R0,D0, Z,R0,
             O, O,5'd11,64'h102, 32'h200, O), "full4");
    apply(mk(Z,R0,D0, Z,R0,D0, Z,R0,
             O, O,5'd12,64'h103, 32'h200, O), "full5");
    apply(mk(Z,R0,D0, Z,R0,D0, Z,R0,
             O, Z,5'd12,64'h103, 32'h200, O), "full6");

    // reset with two queued entries and a pending write
    apply(mk(O,5'd13,64'h130, O,5'd21,64'h210, O,5'd13,
             O, O,5'd21,64'h210, 32'h2200, O), "mrst0");
    apply(mk(O,5'd14,64'h140, O,5'd21,64'h211, O,5'd14,
             O, O,5'd21,64'h211, 32'h6200, O), "mrst1");
    rst = 1'b1;
    drive(mk(Z,R0,D0,Z,R0,D0,Z,R0,Z,Z,R0,D0,32'd0,Z));
    @(negedge clk);
    chk("mrst.alu_ready", 64'(alu_ready), 64'd0);
    chk("mrst.lsu_ready", 64'(lsu_ready), 64'd0);
    @(posedge clk);
    #1;
    chk("mrst.wen", 64'(reg_wr_en), 64'd0);
    chk("mrst.busy", 64'(busy_vec), 64'd0);
    rst = 1'b0;
    apply(mk(Z,R0,D0, Z,R0,D0, Z,R0,
             O, Z,R0,D0, 32'h0, Z), "post0");
    apply(mk(Z,R0,D0, Z,R0,D0, Z,R0,
             O, Z,R0,D0, 32'h0, Z), "post1");

    // randomized run against the queue model
    m_busy  = 32'd0;
    m_wen   = 1'b0;
    m_waddr = 5'd0;
    m_wdata = 64'd0;
    for (int c = 0; c < 3000; c++) begin
      logic acc;
      logic [31:0] nb;
      alu_valid = ($urandom_range(0, 9) < 6);
      alu_rd    = ($urandom_range(0, 7) == 0) ?
                  5'd0 : 5'($urandom_range(1, 31));
      alu_data  = {$urandom, $urandom};
      lsu_valid = ($urandom_range(0, 9) < 4);
      lsu_rd    = ($urandom_range(0, 7) == 0) ?
                  5'd0 : 5'($urandom_range(1, 31));
      lsu_data  = {$urandom, $urandom};
      iss_valid = ($urandom_range(0, 1) == 1);
      iss_rd    = 5'($urandom_range(0, 31));
      rs1_addr  = 5'($urandom_range(0, 31));
      rs2_addr  = 5'($urandom_range(0, 31));
      @(negedge clk);
      chk("rnd.alu_ready", 64'(alu_ready),
          64'(mq_rd.size() < DEPTH));
      chk("rnd.lsu_ready", 64'(lsu_ready), 64'd1);
      chk("rnd.busy_vec", 64'(busy_vec), 64'(m_busy));
      chk("rnd.rs1_busy", 64'(rs1_busy),
          64'(m_busy[rs1_addr]));
      chk("rnd.rs2_busy", 64'(rs2_busy),
          64'(m_busy[rs2_addr]));
      acc = alu_valid && (mq_rd.size() < DEPTH);
      nb = m_busy;
      if (m_wen) nb[m_waddr] = 1'b0;
      if (iss_valid && iss_rd != 5'd0) nb[iss_rd] = 1'b1;
      m_busy = nb;
      if (lsu_valid && lsu_rd != 5'd0) begin
        m_wen = 1'b1;
        m_waddr = lsu_rd;
        m_wdata = lsu_data;
      end else if (mq_rd.size() > 0) begin
        m_wen = 1'b1;
        m_waddr = mq_rd.pop_front();
        m_wdata = mq_d.pop_front();
      end else begin
        m_wen = 1'b0;
      end
      if (acc && alu_rd != 5'd0) begin
        mq_rd.push_back(alu_rd);
        mq_d.push_back(alu_data);
      end
      @(posedge clk);
      #1;
      chk("rnd.wen", 64'(reg_wr_en), 64'(m_wen));
      chk("rnd.waddr", 64'(wr_addr), 64'(m_waddr));
      chk("rnd.wdata", wr_data, m_wdata);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ysyx_22040237_wb_unit.md
# ysyx_22040237_wb_unit

Write-back unit that drives the general-purpose register file's single write port (`reg_wr_en`, `wr_addr`, `wr_data`). It merges results from two producers: the single-cycle ALU path and the multi-cycle LSU load path. The LSU has fixed priority, and ALU results wait in a small FIFO. It also keeps a 32-entry pending-write scoreboard, so decode can stall on read-after-write hazards against registers that have not yet been written back.

## Interface
- `XLEN`, 64, data width of results and of `wr_data`
- `ALU_FIFO_DEPTH`, 2, ALU result FIFO entries (power of two, ≥2)

- `clk`  in  1  system clock, all state on rising edge
- `rst`  in  1  synchronous, active-high reset
- `alu_valid`  in  1  ALU result offered
- `alu_ready`  out  1  ALU result accepted this edge when `alu_valid & alu_ready`
- `alu_rd`  in  5  destination register of ALU result
- `alu_data`  in  XLEN  ALU result value
- `lsu_valid`  in  1  load result offered; LSU cannot be stalled
- `lsu_ready`  out  1  1 whenever not in reset
- `lsu_rd`  in  5  destination register of load result
- `lsu_data`  in  XLEN  load result value
- `iss_valid`  in  1  an instruction writing `iss_rd` issues this cycle
- `iss_rd`  in  5  destination of issuing instruction
- `rs1_addr`, `rs2_addr`  in  5 each  decode source-register queries
- `rs1_busy`, `rs2_busy`  out  1 each  queried register has a pending write (combinational)
- `busy_vec`  out  32  full scoreboard, bit 0 always 0
- `reg_wr_en`  out  1  register-file write enable (registered)
- `wr_addr`  out  5  register-file write address (registered)
- `wr_data`  out  XLEN  register-file write data (registered)

## Operation
- ALU FIFO:
  - Push on `alu_valid & alu_ready & alu_rd != 0`.
  - `alu_ready = !full & !rst`. A full FIFO refuses a push even if a pop occurs in the same cycle.
  - Results with `alu_rd == 0` are accepted (handshake completes) and discarded, with no FIFO entry.
- LSU path:
  - Accepted whenever `lsu_valid`. Results with `lsu_rd == 0` are discarded.
  - Never enqueued; goes straight to the output register.
- Output register select, evaluated each cycle:
  1. `lsu_valid & lsu_rd != 0`: load `{1, lsu_rd, lsu_data}`.
  2. Else, FIFO non-empty: pop the head and load `{1, head.rd, head.data}`.
  3. Else: load `reg_wr_en = 0`. `wr_addr` and `wr_data` hold their previous values.
- An ALU entry pushed this cycle is not eligible to pop until the next cycle (no FIFO bypass).
- FIFO pointers use one extra wrap bit. `full` means pointers are equal except for the wrap bit; `empty` means they are equal. Wrap-around from depth-1 back to 0 must preserve order.
- Scoreboard:
  - Set: `busy[iss_rd]` is set on `iss_valid & iss_rd != 0`.
  - Clear: `busy[wr_addr]` is cleared on an edge where `reg_wr_en == 1`, i.e. the edge on which the register file commits the write.
  - Same register set and cleared on one edge: the set wins.
  - `busy[0]` is constant 0.
  - A write to a non-busy register is legal and leaves it at 0.
- Query outputs: `rs1_busy = busy_vec[rs1_addr]`, `rs2_busy = busy_vec[rs2_addr]`. No forwarding from the output register; the register file resolves same-cycle read-after-write itself.

## Timing
- Reset values:
  - `reg_wr_en = 0`, `wr_addr = 0`, `wr_data = 0`.
  - `busy_vec = 0`.
  - FIFO empty.
  - `alu_ready = 0` and `lsu_ready = 0` while `rst` is high; `alu_ready = 1` in the first cycle after reset.
- LSU latency: accepted at edge E, `reg_wr_en = 1` during cycle E..E+1, and the register file writes at E+1.
- ALU latency: accepted at edge E, earliest output-register load at E+1, and the register file writes at E+2. Each cycle the LSU is valid adds one cycle of delay.
- Throughput: one register write per cycle. Under continuous LSU traffic the FIFO fills after `ALU_FIFO_DEPTH` accepted results, then `alu_ready` drops.
- Reset mid-operation: FIFO contents are lost, a pending output write is cancelled (`reg_wr_en = 0` after the reset edge), and all busy bits are cleared.

## Test plan
- Single ALU result: `alu_valid = 1`, `alu_rd = 5`, `alu_data = 0x1234`, preceded by `iss_valid`, `iss_rd = 5`.
  - Two edges later: `reg_wr_en = 1`, `wr_addr = 5`, `wr_data = 0x1234`.
  - `busy_vec[5]` is 1 until that write edge, then 0.
- Priority: ALU rd=3/0xAA at edge E, then LSU rd=7/0xBB valid at E+1 and E+2.
  - Writes appear in order rd7, rd7, rd3.
  - FIFO holds the ALU entry; `alu_ready` stays 1 with depth 2.
- FIFO full: LSU valid every cycle while 3 ALU results are offered.
  - `alu_ready` drops after 2 are accepted.
  - The third is accepted only after LSU stops and one pop occurs.
  - Write order equals acceptance order across pointer wrap.
- Zero register: `alu_rd = 0` and `lsu_rd = 0` results, plus `iss_rd = 0`.
  - Handshakes complete, there is no `reg_wr_en` pulse, and `busy_vec[0]` stays 0.
- Set/clear collision: `iss_valid`, `iss_rd = 9` on the same edge a write to rd9 commits.
  - `busy_vec[9]` is 1 afterwards.
  - `rs1_addr = 9` gives `rs1_busy = 1`.
- Reset mid-run: assert `rst` with 2 FIFO entries and `reg_wr_en = 1`.
  - The next cycle: `reg_wr_en = 0`, `busy_vec = 0`, FIFO empty.
  - No stale write occurs after reset is released.
